// File: rtl/arya_load_ctrl_pkg.sv
// Shared constants, state encoding and command decode for the arya load sequencer.
package arya_load_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 64;
    localparam int DEFAULT_MEM_ADDR_WIDTH = 10;
    localparam int DEFAULT_RD_LATENCY     = 1;
    localparam int DEFAULT_ERR_CNT_WIDTH  = 16;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;
    localparam int LAT_CNT_WIDTH  = 2;

    localparam int WORD_CNT_WIDTH = 16;
    localparam int STEP_WIDTH     = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_VWAIT  = 3'd4,
        ST_CMP    = 3'd5,
        ST_RUN    = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE   = 2'd0,
        CMD_LOAD   = 2'd1,
        CMD_VERIFY = 2'd2,
        CMD_RUN    = 2'd3
    } cmd_t;

    function automatic int clamp_rd_latency(input int lat);
        if (lat < RD_LATENCY_MIN) return RD_LATENCY_MIN;
        if (lat > RD_LATENCY_MAX) return RD_LATENCY_MAX;
        return lat;
    endfunction

    // Abort is handled ahead of this decode; the rest resolve load > verify > run.
    function automatic cmd_t decode_cmd(input logic load, input logic verify, input logic run);
        if (load)   return CMD_LOAD;
        if (verify) return CMD_VERIFY;
        if (run)    return CMD_RUN;
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/arya_load_ctrl_if.sv
// Word stream from the register block into the load sequencer.
interface arya_load_ctrl_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_ADDR_WIDTH = 10
);
    logic                      wr_valid;
    logic                      wr_ready;
    logic [MEM_ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      wr_last;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_last,
        output wr_ready
    );
endinterface

// File: rtl/arya_load_cmp.sv
// Verify comparator: counts readback mismatches (saturating) and captures the first failing address.
module arya_load_cmp
    import arya_load_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = DEFAULT_MEM_ADDR_WIDTH,
    parameter int ERR_CNT_WIDTH  = DEFAULT_ERR_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      cmp_en,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [DATA_WIDTH-1:0]     expected,
    input  logic [MEM_ADDR_WIDTH-1:0] addr,
    output logic [ERR_CNT_WIDTH-1:0]  err_count,
    output logic [MEM_ADDR_WIDTH-1:0] first_err_addr
);

    logic [ERR_CNT_WIDTH-1:0]  err_count_q, err_count_d;
    logic [MEM_ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;
    logic                      mismatch;

    always_comb begin
        // NOTE: every _d takes its hold value first so no path through the block can infer a latch.
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        mismatch         = cmp_en && (rdata != expected);
        if (clear) begin
            err_count_d      = '0;
            first_err_addr_d = '0;
        end else if (mismatch) begin
            if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            if (err_count_q == '0) first_err_addr_d = addr;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!reset) begin
            err_count_q      <= '0;
            first_err_addr_q <= '0;
        end else begin
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
        end
    end

    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;

endmodule

// File: rtl/arya_load_ctrl.sv
// Load/verify/run sequencer between the software register block and one arya core.
module arya_load_ctrl
    import arya_load_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = DEFAULT_MEM_ADDR_WIDTH,
    parameter int RD_LATENCY     = DEFAULT_RD_LATENCY,
    parameter int ERR_CNT_WIDTH  = DEFAULT_ERR_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_load,
    input  logic                      cmd_verify,
    input  logic                      cmd_run,
    input  logic                      cmd_abort,
    input  logic [STEP_WIDTH-1:0]     cmd_step_budget,
    arya_load_ctrl_if.slave           wr,
    output logic                      core_reset,
    output logic                      core_en,
    output logic                      core_setup_mem,
    output logic                      core_verify_mem,
    output logic                      core_enable_mem,
    output logic [MEM_ADDR_WIDTH-1:0] core_mem_addr,
    output logic [DATA_WIDTH-1:0]     core_mem_wdata,
    input  logic [DATA_WIDTH-1:0]     core_mem_rdata,
    output logic                      busy,
    output logic                      run_done,
    output logic [WORD_CNT_WIDTH-1:0] word_count,
    output logic [ERR_CNT_WIDTH-1:0]  err_count,
    output logic [MEM_ADDR_WIDTH-1:0] first_err_addr,
    output logic [STEP_WIDTH-1:0]     steps_done
);

    localparam int                       RD_LAT_EFF = clamp_rd_latency(RD_LATENCY);
    localparam logic [LAT_CNT_WIDTH-1:0] LAT_INIT   = LAT_CNT_WIDTH'(RD_LAT_EFF - 1);

    state_t                    state_q, state_d;
    logic [WORD_CNT_WIDTH-1:0] word_count_q, word_count_d;
    logic [STEP_WIDTH-1:0]     steps_done_q, steps_done_d;
    logic [STEP_WIDTH-1:0]     budget_q, budget_d;
    logic [STEP_WIDTH-1:0]     steps_inc;
    logic                      run_done_q, run_done_d;
    logic [LAT_CNT_WIDTH-1:0]  lat_cnt_q, lat_cnt_d;
    logic                      last_q, last_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     exp_q, exp_d;

    logic core_reset_q, core_reset_d;
    logic core_en_q, core_en_d;
    logic setup_q, setup_d;
    logic verify_q, verify_d;
    logic enable_q, enable_d;
    logic wr_ready_q, wr_ready_d;

    logic cmp_en;
    logic cmp_clear;
    logic handshake;
    cmd_t cmd;

    assign cmd       = decode_cmd(cmd_load, cmd_verify, cmd_run);
    assign handshake = wr.wr_valid && wr_ready_q;
    assign steps_inc = steps_done_q + 32'd1;

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        steps_done_d = steps_done_q;
        budget_d     = budget_q;
        run_done_d   = run_done_q;
        lat_cnt_d    = lat_cnt_q;
        last_d       = last_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        exp_d        = exp_q;
        cmp_en       = 1'b0;
        cmp_clear    = 1'b0;

        if (cmd_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    case (cmd)
                        CMD_LOAD: begin
                            state_d      = ST_LOAD;
                            word_count_d = '0;
                            run_done_d   = 1'b0;
                        end
                        CMD_VERIFY: begin
                            state_d      = ST_VERIFY;
                            word_count_d = '0;
                            run_done_d   = 1'b0;
                            cmp_clear    = 1'b1;
                        end
                        CMD_RUN: begin
                            state_d      = ST_RUN;
                            steps_done_d = '0;
                            run_done_d   = 1'b0;
                            budget_d     = cmd_step_budget;
                        end
                        default: ;
                    endcase
                end
                ST_LOAD: begin
                    if (handshake) begin
                        addr_d       = wr.wr_addr;
                        wdata_d      = wr.wr_data;
                        last_d       = wr.wr_last;
                        word_count_d = word_count_q + 16'd1;
                        state_d      = ST_WRITE;
                    end
                end
                ST_WRITE: state_d = last_q ? ST_IDLE : ST_LOAD;
                ST_VERIFY: begin
                    if (handshake) begin
                        addr_d       = wr.wr_addr;
                        exp_d        = wr.wr_data;
                        last_d       = wr.wr_last;
                        word_count_d = word_count_q + 16'd1;
                        lat_cnt_d    = LAT_INIT;
                        state_d      = ST_VWAIT;
                    end
                end
                ST_VWAIT: begin
                    if (lat_cnt_q == '0) state_d = ST_CMP;
                    else                 lat_cnt_d = lat_cnt_q - 1'b1;
                end
                ST_CMP: begin
                    cmp_en  = 1'b1;
                    state_d = last_q ? ST_IDLE : ST_VERIFY;
                end
                ST_RUN: begin
                    // A zero budget never matches, so the core runs until aborted and the counter wraps.
                    steps_done_d = steps_inc;
                    if (budget_q != '0 && steps_inc == budget_q) begin
                        state_d    = ST_HALT;
                        run_done_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Core controls are registered from the next state so they change cleanly with the state register.
    always_comb begin
        core_reset_d = !(state_d == ST_RUN || state_d == ST_HALT);
        core_en_d    = (state_d == ST_RUN);
        setup_d      = (state_d == ST_WRITE);
        verify_d     = (state_d == ST_VWAIT);
        enable_d     = setup_d || verify_d;
        wr_ready_d   = (state_d == ST_LOAD) || (state_d == ST_VERIFY);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            steps_done_q <= '0;
            budget_q     <= '0;
            run_done_q   <= 1'b0;
            lat_cnt_q    <= '0;
            last_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_reset_q <= 1'b1;
            core_en_q    <= 1'b0;
            setup_q      <= 1'b0;
            verify_q     <= 1'b0;
            enable_q     <= 1'b0;
            wr_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            steps_done_q <= steps_done_d;
            budget_q     <= budget_d;
            run_done_q   <= run_done_d;
            lat_cnt_q    <= lat_cnt_d;
            last_q       <= last_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_reset_q <= core_reset_d;
            core_en_q    <= core_en_d;
            setup_q      <= setup_d;
            verify_q     <= verify_d;
            enable_q     <= enable_d;
            wr_ready_q   <= wr_ready_d;
        end
    end

    // NOTE: the expected-data register has no reset; it is always written on a verify handshake before CMP reads it.
    always_ff @(posedge clk) begin
        exp_q <= exp_d;
    end

    arya_load_cmp #(
        .DATA_WIDTH     (DATA_WIDTH),
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
        .ERR_CNT_WIDTH  (ERR_CNT_WIDTH)
    ) u_cmp (
        .clk            (clk),
        .reset          (reset),
        .clear          (cmp_clear),
        .cmp_en         (cmp_en),
        .rdata          (core_mem_rdata),
        .expected       (exp_q),
        .addr           (addr_q),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    assign wr.wr_ready       = wr_ready_q;
    assign core_reset        = core_reset_q;
    assign core_en           = core_en_q;
    assign core_setup_mem    = setup_q;
    assign core_verify_mem   = verify_q;
    assign core_enable_mem   = enable_q;
    assign core_mem_addr     = addr_q;
    assign core_mem_wdata    = wdata_q;
    assign busy              = !(state_q == ST_IDLE || state_q == ST_HALT);
    assign run_done          = run_done_q;
    assign word_count        = word_count_q;
    assign steps_done        = steps_done_q;

endmodule

// File: tb/tb_arya_load_ctrl.sv
// Directed bench for arya_load_ctrl: two instances (RD_LATENCY 1 and 3) share stimulus selected by sel.
module tb_arya_load_ctrl;

    localparam int DW  = 64;
    localparam int AW  = 10;
    localparam int ECW = 4;

    logic          clk;
    logic          reset;
    logic          cmd_load, cmd_verify, cmd_run, cmd_abort;
    logic [31:0]   cmd_step_budget;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          sel;
    logic [AW-1:0] corrupt_addr;

    int checks;
    int errors;
    int setup_pulses;

    logic          core_reset_1, core_en_1, setup_1, verify_1, enable_1, busy_1, run_done_1;
    logic [AW-1:0] addr_1, first_1;
    logic [DW-1:0] wdata_1, rdata_1;
    logic [15:0]   wc_1;
    logic [ECW-1:0] err_1;
    logic [31:0]   steps_1;

    logic          core_reset_3, core_en_3, setup_3, verify_3, enable_3, busy_3, run_done_3;
    logic [AW-1:0] addr_3, first_3;
    logic [DW-1:0] wdata_3, rdata_3;
    logic [15:0]   wc_3;
    logic [ECW-1:0] err_3;
    logic [31:0]   steps_3;

    arya_load_ctrl_if #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) if1 ();
    arya_load_ctrl_if #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) if3 ();

    assign if1.wr_valid = wr_valid & ~sel;
    assign if1.wr_addr  = wr_addr;
    assign if1.wr_data  = wr_data;
    assign if1.wr_last  = wr_last;
    assign if3.wr_valid = wr_valid & sel;
    assign if3.wr_addr  = wr_addr;
    assign if3.wr_data  = wr_data;
    assign if3.wr_last  = wr_last;

    arya_load_ctrl #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .RD_LATENCY(1), .ERR_CNT_WIDTH(ECW)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_load(cmd_load & ~sel), .cmd_verify(cmd_verify & ~sel),
        .cmd_run(cmd_run & ~sel), .cmd_abort(cmd_abort & ~sel),
        .cmd_step_budget(cmd_step_budget), .wr(if1),
        .core_reset(core_reset_1), .core_en(core_en_1), .core_setup_mem(setup_1),
        .core_verify_mem(verify_1), .core_enable_mem(enable_1), .core_mem_addr(addr_1),
        .core_mem_wdata(wdata_1), .core_mem_rdata(rdata_1), .busy(busy_1), .run_done(run_done_1),
        .word_count(wc_1), .err_count(err_1), .first_err_addr(first_1), .steps_done(steps_1)
    );

    arya_load_ctrl #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .RD_LATENCY(3), .ERR_CNT_WIDTH(ECW)) dut3 (
        .clk(clk), .reset(reset),
        .cmd_load(cmd_load & sel), .cmd_verify(cmd_verify & sel),
        .cmd_run(cmd_run & sel), .cmd_abort(cmd_abort & sel),
        .cmd_step_budget(cmd_step_budget), .wr(if3),
        .core_reset(core_reset_3), .core_en(core_en_3), .core_setup_mem(setup_3),
        .core_verify_mem(verify_3), .core_enable_mem(enable_3), .core_mem_addr(addr_3),
        .core_mem_wdata(wdata_3), .core_mem_rdata(rdata_3), .busy(busy_3), .run_done(run_done_3),
        .word_count(wc_3), .err_count(err_3), .first_err_addr(first_3), .steps_done(steps_3)
    );

    // Observed view of whichever instance is selected.
    logic          o_core_reset, o_core_en, o_setup, o_verify, o_enable, o_busy, o_run_done, o_wr_ready;
    logic [AW-1:0] o_addr, o_first;
    logic [DW-1:0] o_wdata;
    logic [15:0]   o_wc;
    logic [ECW-1:0] o_err;
    logic [31:0]   o_steps;

    assign o_core_reset = sel ? core_reset_3 : core_reset_1;
    assign o_core_en    = sel ? core_en_3    : core_en_1;
    assign o_setup      = sel ? setup_3      : setup_1;
    assign o_verify     = sel ? verify_3     : verify_1;
    assign o_enable     = sel ? enable_3     : enable_1;
    assign o_busy       = sel ? busy_3       : busy_1;
    assign o_run_done   = sel ? run_done_3   : run_done_1;
    assign o_wr_ready   = sel ? if3.wr_ready : if1.wr_ready;
    assign o_addr       = sel ? addr_3       : addr_1;
    assign o_first      = sel ? first_3      : first_1;
    assign o_wdata      = sel ? wdata_3      : wdata_1;
    assign o_wc         = sel ? wc_3         : wc_1;
    assign o_err        = sel ? err_3        : err_1;
    assign o_steps      = sel ? steps_3      : steps_1;

    // Core memory models; readback at corrupt_addr has bit 0 flipped.
    logic [DW-1:0] mem1 [0:1023];
    logic [DW-1:0] mem3 [0:1023];
    logic [DW-1:0] p3_0, p3_1, p3_2;

    function automatic logic [DW-1:0] flip(input logic [AW-1:0] a);
        return (a == corrupt_addr) ? 64'h1 : 64'h0;
    endfunction

    always @(posedge clk) begin
        if (setup_1 && enable_1) mem1[addr_1] <= wdata_1;
        if (setup_3 && enable_3) mem3[addr_3] <= wdata_3;
        rdata_1 <= mem1[addr_1] ^ flip(addr_1);
        p3_0    <= mem3[addr_3] ^ flip(addr_3);
        p3_1    <= p3_0;
        p3_2    <= p3_1;
        if (o_setup && o_enable) setup_pulses <= setup_pulses + 1;
    end
    assign rdata_3 = p3_2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 64'(o_busy), 0);
    endtask

    // mode 0: load word, mode 1: verify word with VWAIT length check, mode 2: return at first VWAIT cycle
    task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last,
                             input int mode, input int lat);
        int n;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_last  = last;
        n = 0;
        while (!o_wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready_wait", 64'(o_wr_ready), 1);
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        if (mode == 0) begin
            check("write_setup", 64'(o_setup), 1);
            check("write_enable", 64'(o_enable), 1);
            check("write_addr", 64'(o_addr), 64'(a));
            check("write_data", o_wdata, d);
            @(negedge clk);
            check("write_pulse_end", 64'(o_setup), 0);
        end else if (mode == 1) begin
            check("verify_addr", 64'(o_addr), 64'(a));
            check("verify_enable", 64'(o_enable), 1);
            n = 0;
            while (o_verify && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("vwait_cycles", 64'(n), 64'(lat));
        end
    endtask

    task automatic load_block(input int base, input int n, input logic [DW-1:0] hi);
        cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        for (int i = 0; i < n; i++)
            send_word(AW'(base + i), hi | 64'(base + i), (i == n - 1), 0, 0);
        wait_idle();
    endtask

    task automatic verify_block(input int base, input int n, input logic [DW-1:0] hi,
                                input logic [DW-1:0] mask, input int lat);
        cmd_verify = 1'b1;
        @(negedge clk);
        cmd_verify = 1'b0;
        for (int i = 0; i < n; i++)
            send_word(AW'(base + i), (hi | 64'(base + i)) ^ mask, (i == n - 1), 1, lat);
        wait_idle();
    endtask

    task automatic run_budget(input logic [31:0] budget, input int expect_cycles);
        int n;
        cmd_run         = 1'b1;
        cmd_step_budget = budget;
        @(negedge clk);
        cmd_run         = 1'b0;
        cmd_step_budget = 32'd3;
        check("run_core_reset", 64'(o_core_reset), 0);
        check("run_done_cleared", 64'(o_run_done), 0);
        n = 0;
        while (o_core_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("run_en_cycles", 64'(n), 64'(expect_cycles));
        check("halt_busy", 64'(o_busy), 0);
        check("halt_run_done", 64'(o_run_done), 1);
        check("halt_steps", 64'(o_steps), 64'(expect_cycles));
        check("halt_core_reset", 64'(o_core_reset), 0);
    endtask

    initial begin
        checks = 0; errors = 0; setup_pulses = 0;
        reset = 1'b0; sel = 1'b0; corrupt_addr = 10'd2;
        cmd_load = 0; cmd_verify = 0; cmd_run = 0; cmd_abort = 0;
        cmd_step_budget = '0;
        wr_valid = 1'b1; wr_addr = '0; wr_data = '0; wr_last = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_core_reset", 64'(o_core_reset), 1);
        check("rst_core_en", 64'(o_core_en), 0);
        check("rst_wr_ready", 64'(o_wr_ready), 0);
        check("rst_busy", 64'(o_busy), 0);
        check("rst_strobes", 64'({o_setup, o_verify, o_enable}), 0);
        check("rst_addr", 64'(o_addr), 0);
        check("rst_wdata", o_wdata, 0);
        check("rst_word_count", 64'(o_wc), 0);
        check("rst_err_count", 64'(o_err), 0);
        check("rst_first_err", 64'(o_first), 0);
        check("rst_steps", o_steps, 0);
        check("rst_run_done", 64'(o_run_done), 0);

        reset = 1'b1;
        @(negedge clk);
        check("idle_valid_ignored", 64'(o_wr_ready), 0);
        check("idle_wc", 64'(o_wc), 0);
        wr_valid = 1'b0;

        // Load and verify on the RD_LATENCY=1 instance.
        load_block(0, 4, 64'hA5A5_0000_0000_0000);
        check("load1_pulses", 64'(setup_pulses), 4);
        check("load1_wc", 64'(o_wc), 4);
        verify_block(0, 4, 64'hA5A5_0000_0000_0000, 64'h0, 1);
        check("ver1_err", 64'(o_err), 1);
        check("ver1_first", 64'(o_first), 2);
        check("ver1_wc", 64'(o_wc), 4);

        // Same on the RD_LATENCY=3 instance.
        sel = 1'b1;
        @(negedge clk);
        load_block(0, 4, 64'hA5A5_0000_0000_0000);
        check("load3_wc", 64'(o_wc), 4);
        verify_block(0, 4, 64'hA5A5_0000_0000_0000, 64'h0, 3);
        check("ver3_err", 64'(o_err), 1);
        check("ver3_first", 64'(o_first), 2);
        check("ver3_wc", 64'(o_wc), 4);

        // Abort in VWAIT together with a load command.
        cmd_verify = 1'b1;
        @(negedge clk);
        cmd_verify = 1'b0;
        send_word(10'd0, 64'hA5A5_0000_0000_0000, 1'b0, 2, 0);
        check("abort_in_vwait", 64'(o_verify), 1);
        cmd_abort = 1'b1;
        cmd_load  = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        cmd_load  = 1'b0;
        check("abort_busy", 64'(o_busy), 0);
        check("abort_strobes", 64'({o_setup, o_verify, o_enable}), 0);
        check("abort_wr_ready", 64'(o_wr_ready), 0);
        check("abort_core_reset", 64'(o_core_reset), 1);
        check("abort_wc_held", 64'(o_wc), 1);
        check("abort_err_cleared", 64'(o_err), 0);
        @(negedge clk);
        check("abort_load_ignored", 64'(o_wr_ready), 0);

        // Bounded runs on the RD_LATENCY=1 instance.
        sel = 1'b0;
        @(negedge clk);
        run_budget(32'd10, 10);
        run_budget(32'd5, 5);

        // Unbounded run from HALT; verify during RUN is ignored; abort after 20 steps.
        cmd_run = 1'b1;
        cmd_step_budget = 32'd0;
        @(negedge clk);
        cmd_run = 1'b0;
        repeat (5) @(negedge clk);
        cmd_verify = 1'b1;
        @(negedge clk);
        cmd_verify = 1'b0;
        check("run_verify_ignored_en", 64'(o_core_en), 1);
        check("run_verify_ignored_rdy", 64'(o_wr_ready), 0);
        repeat (14) @(negedge clk);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        check("run_abort_en", 64'(o_core_en), 0);
        check("run_abort_core_reset", 64'(o_core_reset), 1);
        check("run_abort_busy", 64'(o_busy), 0);
        check("run_abort_steps", o_steps, 20);
        check("run_abort_run_done", 64'(o_run_done), 0);

        // Error counter saturation: 18 mismatching words with a 4-bit counter.
        corrupt_addr = 10'd1023;
        load_block(16, 18, 64'hC0DE_0000_0000_0000);
        verify_block(16, 18, 64'hC0DE_0000_0000_0000, 64'h1, 1);
        check("sat_err", 64'(o_err), 15);
        check("sat_first", 64'(o_first), 16);
        check("sat_wc", 64'(o_wc), 18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arya_load_ctrl.md
Name: arya_load_ctrl

Overview:
Sequencer that sits between the software register block and one arya core. It drives the core's reset, enable, setup_mem, verify_mem and enable_mem controls. It streams program words into core memory, then re-streams expected words and compares them against readback. Finally it releases the core for a bounded or free-running cycle budget and reports status back to hardware registers.

Parameters:
DATA_WIDTH, 64, memory word width
MEM_ADDR_WIDTH, 10, core memory address width
RD_LATENCY, 1, cycles from verify address presentation to valid core_mem_rdata (range 1..4)
ERR_CNT_WIDTH, 16, mismatch counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low (0 = reset)
cmd_load  in  1  single-cycle pulse: begin load pass
cmd_verify  in  1  pulse: begin verify pass
cmd_run  in  1  pulse: release core for a run
cmd_abort  in  1  pulse: return to IDLE from any state
cmd_step_budget  in  32  run length in clk cycles; 0 = unbounded
wr_valid  in  1  word stream valid
wr_ready  out  1  word stream ready
wr_addr  in  MEM_ADDR_WIDTH  word address
wr_data  in  DATA_WIDTH  word data (write data or expected data)
wr_last  in  1  final word of the pass
core_reset  out  1  core reset, active-high
core_en  out  1  core clock enable
core_setup_mem  out  1  core memory write select
core_verify_mem  out  1  core memory read select
core_enable_mem  out  1  core memory access strobe
core_mem_addr  out  MEM_ADDR_WIDTH  core memory address
core_mem_wdata  out  DATA_WIDTH  core memory write data
core_mem_rdata  in  DATA_WIDTH  core memory readback
busy  out  1  state not IDLE/HALT
run_done  out  1  budget exhausted, sticky until next command
word_count  out  16  words accepted in current/last pass
err_count  out  ERR_CNT_WIDTH  verify mismatches, saturating
first_err_addr  out  MEM_ADDR_WIDTH  address of first mismatch
steps_done  out  32  cycles run since last cmd_run

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; core_reset=1; core_en=0.
  - All mem strobes=0; core_mem_addr/wdata=0; wr_ready=0.
  - All counters=0; run_done=0; first_err_addr=0.
- States: IDLE, LOAD, WRITE, VERIFY, VWAIT, CMP, RUN, HALT.
- core_reset=1 in IDLE, LOAD, WRITE, VERIFY, VWAIT and CMP. core_reset=0 in RUN and HALT.
- core_en=1 only in RUN.
- Commands are accepted only in IDLE or HALT.
  - Priority: abort > load > verify > run.
  - Commands in any other state are ignored, except cmd_abort.
- cmd_abort in any state → IDLE next cycle. All strobes drop that cycle. Counters hold their values.
- cmd_load → LOAD. Clears word_count.
- LOAD: wr_ready=1. On wr_valid & wr_ready:
  - register addr/data onto core_mem_addr/wdata;
  - increment word_count;
  - latch wr_last;
  - go to WRITE.
- WRITE, one cycle: core_setup_mem=1, core_enable_mem=1, wr_ready=0. Then → IDLE if last was latched, else → LOAD.
  - Throughput: 1 word per 2 cycles.
- cmd_verify → VERIFY. Clears word_count, err_count and first_err_addr.
- VERIFY: wr_ready=1. On handshake:
  - latch expected data and last;
  - drive core_mem_addr;
  - go to VWAIT.
- VWAIT: core_verify_mem=1, core_enable_mem=1 for RD_LATENCY cycles (internal down-counter). Then → CMP.
- CMP, one cycle: compare core_mem_rdata against expected data.
  - On mismatch: err_count += 1, saturating at all-ones.
  - If err_count was 0, record first_err_addr.
  - Then → IDLE if last, else → VERIFY.
- cmd_run → RUN. Clears steps_done and run_done.
- RUN: steps_done += 1 per cycle.
  - If budget≠0 and steps_done+1 == budget → HALT with run_done=1. core_en is high for exactly budget cycles.
  - If budget==0: run until abort. steps_done wraps at 2^32.
- HALT: core state preserved (no reset). cmd_run resumes with a fresh budget. cmd_load/cmd_verify put the core back in reset.
- cmd_step_budget is sampled on the cmd_run cycle; later changes are ignored.
- wr_valid outside LOAD/VERIFY: ignored, wr_ready=0.
- wr_data/wr_addr must be held only during the handshake cycle.

Decomposition:
- Shared package/header: state encodings, RD_LATENCY bounds and default widths as named constants.
- Sub-module: arya_load_cmp, the registered comparator plus saturating err_count and first-error capture.

Test Plan:
- Reset low 3 cycles with wr_valid=1 → core_reset=1, wr_ready=0, all counters 0, state IDLE.
- Load 4 words to addr 0..3 with data 64'hA5A5_0000_0000_000n and last on word 3 → 4 core_setup_mem pulses, each 1 cycle with matching addr/data; word_count=4; IDLE after the 4th WRITE.
- Verify the same 4 words, model returning data with a mismatch at addr 2 (RD_LATENCY=1 and 3) → err_count=1, first_err_addr=2, word_count=4.
- cmd_run with budget=10 → core_en high exactly 10 cycles, core_reset=0, steps_done=10, run_done=1, HALT; a second cmd_run with budget=5 → 5 more cycles, steps_done=5.
- cmd_abort mid-VWAIT, and the same cycle as cmd_load → IDLE next cycle, strobes 0, load ignored; a cmd_verify during RUN is ignored.
- 2^ERR_CNT_WIDTH+2 mismatching words (ERR_CNT_WIDTH=4 in bench) → err_count saturates at 15; first_err_addr stays the first address.
